apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_wait_watchdog.sv | 39 +++
 rtl/apb_master_bridge.sv | 119 +++++++++++
 tb/tb_apb_master_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge and its watchdog.
// Command and response structs use the package widths, which are the bridge defaults.
package apb_pkg;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;
    localparam int WD_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_watchdog.sv
// Saturating count of ACCESS wait states; expired_o flags the wait cycle that reaches TIMEOUT.
module apb_wait_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic PCLK_i,
    input  logic PRESETn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WD_CNT_W-1:0] LAST_WAIT = WD_CNT_W'(TIMEOUT - 1);

    logic [WD_CNT_W-1:0] count_q;
    logic [WD_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK_i) begin
        if (!PRESETn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The current wait cycle is the TIMEOUT-th one when TIMEOUT-1 waits are already counted.
    assign expired_o = enable_i && (count_q >= LAST_WAIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns read data and error/timeout status on a held response channel.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK_i,
    input  logic              PRESETn_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              PSEL_o,
    output logic              PENABLE_o,
    output logic              PWRITE_o,
    output logic [ADDR_W-1:0] PADDR_o,
    output logic [DATA_W-1:0] PWDATA_o,
    input  logic [DATA_W-1:0] PRDATA_i,
    input  logic              PREADY_i,
    input  logic              PSLVERR_i
);

    apb_state_e state_q;
    apb_cmd_t   cmd_q;
    apb_rsp_t   rsp_q;
    logic       psel_q;
    logic       penable_q;
    logic       rsp_valid_q;

    logic wd_enable;
    logic wd_clear;
    logic wd_expired;

    assign wd_enable = (state_q == ACCESS) && !PREADY_i;
    assign wd_clear  = (state_q == RESP) && rsp_ready_i;

    apb_wait_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .PCLK_i   (PCLK_i),
        .PRESETn_i(PRESETn_i),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );

    always_ff @(posedge PCLK_i) begin
        if (!PRESETn_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_q   <= '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
                        psel_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over the watchdog on the limit cycle.
                    if (PREADY_i) begin
                        rsp_q <= '{rdata:   (cmd_q.write ? {APB_DATA_W{1'b0}} : PRDATA_i),
                                   err:     PSLVERR_i,
                                   timeout: 1'b0};
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (wd_expired) begin
                        rsp_q       <= '{rdata: {APB_DATA_W{1'b0}}, err: 1'b1, timeout: 1'b1};
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE) && PRESETn_i;
    assign PSEL_o        = psel_q;
    assign PENABLE_o     = penable_q;
    assign PWRITE_o      = cmd_q.write;
    assign PADDR_o       = cmd_q.addr;
    assign PWDATA_o      = cmd_q.wdata;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a per-cycle timeline model of each transfer
// is compared against the DUT on every falling edge, plus literal pins per scenario.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              pclk = 1'b0;
    logic              presetN;
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdWrite;
    logic [ADDR_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdWdata;
    logic              rspValid;
    logic              rspReady;
    logic [DATA_W-1:0] rspRdata;
    logic              rspErr;
    logic              rspTimeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    bit checkEn    = 1'b0;

    // Model of the transfer in flight, as absolute cycle numbers.
    bit          txActive = 1'b0;
    int          expE;
    int          expAcc;
    int          expRel;
    logic        expWrite;
    logic [7:0]  expAddr;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    logic        expErr;
    logic        expTo;

    bit planReadyTied = 1'b0;
    bit planSetupErr  = 1'b0;
    bit planWaitErr   = 1'b0;
    bit planEarlyCmd  = 1'b0;

    int          obsPselOff;
    int          obsPenOff;
    int          obsRspOff;
    int          obsAccess;
    int          obsRspLen;
    int          obsPselCyc;
    logic [31:0] obsRdata;
    logic        obsErr;
    logic        obsTo;
    logic [7:0]  obsAddrFirst;
    bit          obsAddrStable;

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK_i       (pclk),
        .PRESETn_i    (presetN),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReady),
        .cmd_write_i  (cmdWrite),
        .cmd_addr_i   (cmdAddr),
        .cmd_wdata_i  (cmdWdata),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_rdata_o  (rspRdata),
        .rsp_err_o    (rspErr),
        .rsp_timeout_o(rspTimeout),
        .PSEL_o       (psel),
        .PENABLE_o    (penable),
        .PWRITE_o     (pwrite),
        .PADDR_o      (paddr),
        .PWDATA_o     (pwdata),
        .PRDATA_i     (prdata),
        .PREADY_i     (pready),
        .PSLVERR_i    (pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One command through the bridge; the slave answers after 'waits' wait states
    // (never if waits >= TIMEOUT). resetAt > 0 pulses reset in that ACCESS cycle.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata, input logic slvErr,
                                 input int rspHold, input int resetAt);
        bit timedOut;
        int acc;
        timedOut = (waits >= TIMEOUT);
        acc      = timedOut ? TIMEOUT : waits + 1;
        expE     = cyc + 1;
        expAcc   = acc;
        expRel   = cyc + 1 + acc + 1 + rspHold;
        expWrite = wr;
        expAddr  = addr;
        expWdata = wdata;
        expRdata = (wr || timedOut) ? 32'h0 : rdata;
        expErr   = timedOut || slvErr;
        expTo    = timedOut;
        obsPselOff = -1; obsPenOff = -1; obsRspOff = -1; obsAccess = 0; obsRspLen = 0;
        obsPselCyc = -1; obsAddrStable = 1'b1;
        txActive = 1'b1;
        cmdValid = 1'b1; cmdWrite = wr; cmdAddr = addr; cmdWdata = wdata;
        tick();
        cmdValid = 1'b0;
        pready   = planReadyTied;
        pslverr  = planSetupErr;
        prdata   = 32'hFFFF_FFFF;
        for (int k = 1; k <= acc; k++) begin
            tick();
            pready  = (k == waits + 1) || planReadyTied;
            prdata  = (k == waits + 1) ? rdata : 32'h5A5A_0000 + k;
            pslverr = (k == waits + 1) ? slvErr : planWaitErr;
            if (k == resetAt) begin
                presetN = 1'b0;
                tick();
                presetN  = 1'b1;
                txActive = 1'b0;
                pready   = 1'b0;
                pslverr  = 1'b0;
                return;
            end
        end
        tick();
        pready  = planReadyTied;
        pslverr = 1'b0;
        for (int j = 0; j < rspHold; j++) begin
            rspReady = 1'b0;
            if (planEarlyCmd) begin
                cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 8'hEE; cmdWdata = 32'h0BAD_0BAD;
            end
            tick();
        end
        rspReady = 1'b1;
        cmdValid = 1'b0;
        tick();
        rspReady = 1'b0;
        pready   = 1'b0;
        txActive = 1'b0;
    endtask

    always @(negedge pclk) begin
        bit inTx;
        bit eSel;
        bit eEn;
        bit eRsp;
        if (checkEn) begin
            inTx = txActive && (cyc >= expE) && (cyc <= expRel);
            eSel = txActive && (cyc >= expE) && (cyc <= expE + expAcc);
            eEn  = txActive && (cyc >= expE + 1) && (cyc <= expE + expAcc);
            eRsp = txActive && (cyc > expE + expAcc) && (cyc <= expRel);
            checkOutput("cmd_ready", cmdReady, presetN && !inTx);
            checkOutput("PSEL", psel, eSel);
            checkOutput("PENABLE", penable, eEn);
            checkOutput("rsp_valid", rspValid, eRsp);
            if (eSel) begin
                checkOutput("PADDR", paddr, expAddr);
                checkOutput("PWRITE", pwrite, expWrite);
                checkOutput("PWDATA", pwdata, expWdata);
            end
            if (eRsp) begin
                checkOutput("rsp_rdata", rspRdata, expRdata);
                checkOutput("rsp_err", rspErr, expErr);
                checkOutput("rsp_timeout", rspTimeout, expTo);
            end
            if (txActive) begin
                if (psel && obsPselOff < 0) begin
                    obsPselOff = cyc - (expE - 1);
                    obsPselCyc = cyc;
                end
                if (penable && obsPenOff < 0) obsPenOff = cyc - (expE - 1);
                if (psel && penable) begin
                    if (obsAccess == 0) obsAddrFirst = paddr;
                    else if (paddr !== obsAddrFirst) obsAddrStable = 1'b0;
                    obsAccess++;
                end
                if (rspValid) begin
                    if (obsRspOff < 0) begin
                        obsRspOff = cyc - (expE - 1);
                        obsRdata  = rspRdata;
                        obsErr    = rspErr;
                        obsTo     = rspTimeout;
                    end
                    obsRspLen++;
                end
            end
        end
    end

    initial begin
        int pselA;
        presetN = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdWdata = '0;
        rspReady = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

        tick();
        checkEn = 1'b1;
        checkOutput("rst PSEL", psel, 0);
        checkOutput("rst PENABLE", penable, 0);
        checkOutput("rst PWRITE", pwrite, 0);
        checkOutput("rst PADDR", paddr, 0);
        checkOutput("rst PWDATA", pwdata, 0);
        checkOutput("rst rsp_valid", rspValid, 0);
        checkOutput("rst rsp_rdata", rspRdata, 0);
        checkOutput("rst rsp_err", rspErr, 0);
        checkOutput("rst rsp_timeout", rspTimeout, 0);
        tick();
        presetN = 1'b1;
        tick();

        $display("[TB] zero-wait write, PREADY tied high");
        planReadyTied = 1'b1;
        applyStimulus(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h1111_2222, 1'b0, 0, 0);
        planReadyTied = 1'b0;
        checkOutput("wr psel cycle", obsPselOff, 1);
        checkOutput("wr penable cycle", obsPenOff, 2);
        checkOutput("wr rsp cycle", obsRspOff, 3);
        checkOutput("wr rdata", obsRdata, 32'h0);
        checkOutput("wr err", obsErr, 0);

        $display("[TB] read with 3 wait states");
        planWaitErr = 1'b1;
        applyStimulus(1'b0, 8'h24, 32'h0, 3, 32'hA5A5_0001, 1'b0, 0, 0);
        planWaitErr = 1'b0;
        checkOutput("rd3 access cycles", obsAccess, 4);
        checkOutput("rd3 paddr stable", obsAddrStable, 1);
        checkOutput("rd3 rsp cycle", obsRspOff, 6);
        checkOutput("rd3 rdata", obsRdata, 32'hA5A5_0001);
        checkOutput("rd3 err", obsErr, 0);

        $display("[TB] slave error on read");
        applyStimulus(1'b0, 8'h30, 32'h0, 1, 32'h1234_5678, 1'b1, 0, 0);
        checkOutput("slverr err", obsErr, 1);
        checkOutput("slverr timeout", obsTo, 0);
        checkOutput("slverr rdata", obsRdata, 32'h1234_5678);

        $display("[TB] PSLVERR pulsed in SETUP only");
        planSetupErr = 1'b1;
        applyStimulus(1'b0, 8'h34, 32'h0, 0, 32'h0000_BEEF, 1'b0, 0, 0);
        planSetupErr = 1'b0;
        checkOutput("setup pslverr err", obsErr, 0);
        checkOutput("setup pslverr rdata", obsRdata, 32'h0000_BEEF);

        $display("[TB] watchdog timeout");
        applyStimulus(1'b0, 8'h40, 32'h0, 200, 32'h7777_7777, 1'b0, 0, 0);
        checkOutput("to access cycles", obsAccess, 4);
        checkOutput("to rsp cycle", obsRspOff, 6);
        checkOutput("to err", obsErr, 1);
        checkOutput("to timeout", obsTo, 1);
        checkOutput("to rdata", obsRdata, 32'h0);

        $display("[TB] PREADY on the limit cycle");
        applyStimulus(1'b0, 8'h44, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 0, 0);
        checkOutput("limit timeout", obsTo, 0);
        checkOutput("limit err", obsErr, 0);
        checkOutput("limit rdata", obsRdata, 32'h0BAD_F00D);

        $display("[TB] response backpressure");
        planEarlyCmd = 1'b1;
        applyStimulus(1'b1, 8'h50, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 5, 0);
        planEarlyCmd = 1'b0;
        checkOutput("bp rsp cycle", obsRspOff, 3);
        checkOutput("bp rsp held cycles", obsRspLen, 6);

        $display("[TB] back-to-back reads");
        applyStimulus(1'b0, 8'h60, 32'h0, 0, 32'h600D_CAFE, 1'b0, 0, 0);
        pselA = obsPselCyc;
        applyStimulus(1'b0, 8'h64, 32'h0, 0, 32'hC0FF_EE11, 1'b0, 0, 0);
        checkOutput("b2b spacing", obsPselCyc - pselA, 4);
        checkOutput("b2b rdata", obsRdata, 32'hC0FF_EE11);

        $display("[TB] reset during ACCESS");
        applyStimulus(1'b0, 8'h70, 32'h0, 10, 32'h0, 1'b0, 0, 2);
        checkOutput("midrst PSEL", psel, 0);
        checkOutput("midrst PENABLE", penable, 0);
        checkOutput("midrst rsp_valid", rspValid, 0);
        checkOutput("midrst rsp_rdata", rspRdata, 0);
        checkOutput("midrst PADDR", paddr, 0);
        applyStimulus(1'b1, 8'h74, 32'h1357_2468, 1, 32'h0, 1'b0, 0, 0);
        checkOutput("postrst rsp cycle", obsRspOff, 4);
        checkOutput("postrst err", obsErr, 0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
